// File: rtl/move_gather_arbiter.sv
// Drains N source move FIFOs (fixed-priority or round-robin) into one output FIFO under start/done control.
// start->first src_rden 2 cycles, src_rden->word visible 2 cycles; reads stall while the output FIFO lacks room.
module move_gather_arbiter #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 160,
   parameter int DEPTH  = 64,
   parameter int MODE   = 0,
   parameter int TAG_EN = 0,
   localparam int CW    = $clog2(N_CH),
   localparam int AW    = $clog2(DEPTH),
   localparam int OUT_W = DATA_W + ((TAG_EN != 0) ? CW : 0)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [N_CH-1:0]        src_done,
   input  logic [N_CH-1:0]        src_empty,
   input  logic [N_CH*DATA_W-1:0] src_data,
   output logic [N_CH-1:0]        src_rden,
   input  logic                   out_rden,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_empty,
   output logic                   out_full,
   output logic [AW:0]            out_count,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
   localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   state_t          r_state;
   logic [N_CH-1:0] r_drained;
   logic [CW-1:0]   r_ptr;
   logic [CW-1:0]   r_rr_last;
   logic            r_pend;

   logic [N_CH-1:0] w_elig;
   logic [N_CH-1:0] w_marks;
   logic [N_CH-1:0] w_cand;
   logic [N_CH-1:0] w_drained_nxt;
   logic [CW-1:0]   w_pick;
   logic            w_pick_vld;
   logic            w_room;

   logic [OUT_W-1:0]  r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              w_wr;
   logic              w_rd;
   logic [DATA_W-1:0] w_sel;
   logic [OUT_W-1:0]  w_wdat;

   assign w_elig        = src_done & ~r_drained;
   assign w_marks       = w_elig & src_empty;
   assign w_cand        = w_elig & ~src_empty;
   assign w_drained_nxt = r_drained | w_marks;

   // The in-flight read (r_pend) counts as occupied so a write can never land on a full FIFO.
   assign w_room = ({1'b0, r_count} + {{(AW+1){1'b0}}, r_pend}) < DEPTH_X;

   always_comb begin
      int idx;
      w_pick     = '0;
      w_pick_vld = 1'b0;
      idx        = 0;
      if (MODE == 0) begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_cand[i]) begin
               w_pick     = CW'(i);
               w_pick_vld = 1'b1;
            end
         end
      end else begin
         // Walk from farthest to nearest so the last hit is the first channel after r_rr_last.
         for (int k = N_CH; k >= 1; k--) begin
            idx = int'(r_rr_last) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (w_cand[idx]) begin
               w_pick     = CW'(idx);
               w_pick_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      src_rden = '0;
      if (r_state == S_DRAIN && !src_empty[r_ptr] && w_room) src_rden[r_ptr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_drained <= '0;
         r_ptr     <= '0;
         r_rr_last <= LAST_CH;
         r_pend    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_pend <= |src_rden;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_drained <= '0;
                  r_state   <= S_SCAN;
                  busy      <= 1'b1;
               end
            end
            S_SCAN: begin
               r_drained <= w_drained_nxt;
               if (w_pick_vld) begin
                  r_ptr   <= w_pick;
                  r_state <= S_DRAIN;
               end else if (&w_drained_nxt) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (src_empty[r_ptr] && !r_pend) begin
                  r_drained[r_ptr] <= 1'b1;
                  r_rr_last        <= r_ptr;
                  r_state          <= S_SCAN;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_drained <= '0;
                  r_state   <= S_SCAN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_sel = src_data[int'(r_ptr)*DATA_W +: DATA_W];

   generate
      if (TAG_EN != 0) begin : g_tag
         assign w_wdat = {r_ptr, w_sel};
      end else begin : g_notag
         assign w_wdat = w_sel;
      end
   endgenerate

   assign w_wr      = r_pend;
   assign w_rd      = out_rden && (r_count != '0);
   assign out_empty = (r_count == '0);
   assign out_full  = (r_count == DEPTH_C);
   assign out_count = r_count;

   always_ff @(posedge clk) begin
      if (w_wr && !reset) r_mem[r_wptr] <= w_wdat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         out_data <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) begin
            out_data <= r_mem[r_rptr];
            r_rptr   <= r_rptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!reset) a_no_overflow: assert (!(w_wr && out_full));
   end

endmodule

// File: tb/tb_move_gather_arbiter.sv
// Two gather instances (fixed-priority untagged DEPTH 4, round-robin tagged DEPTH 8) fed by modelled source FIFOs.
module tb_move_gather_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         start     [2];
   logic [7:0]   src_done  [2];
   logic [7:0]   src_empty [2];
   logic [7:0]   src_rden  [2];
   logic [255:0] src_data  [2];
   logic         out_rden  [2];
   logic         out_empty [2];
   logic         out_full  [2];
   logic         busy      [2];
   logic         done      [2];
   logic [31:0]  od0;
   logic [34:0]  od1;
   logic [2:0]   oc0;
   logic [3:0]   oc1;
   logic [34:0]  od [2];
   logic [3:0]   oc [2];

   assign od[0] = {3'b000, od0};
   assign od[1] = od1;
   assign oc[0] = {1'b0, oc0};
   assign oc[1] = oc1;

   move_gather_arbiter #(.N_CH(8), .DATA_W(32), .DEPTH(4), .MODE(0), .TAG_EN(0)) u_fp (
      .clk(clk), .reset(reset), .start(start[0]), .src_done(src_done[0]),
      .src_empty(src_empty[0]), .src_data(src_data[0]), .src_rden(src_rden[0]),
      .out_rden(out_rden[0]), .out_data(od0), .out_empty(out_empty[0]),
      .out_full(out_full[0]), .out_count(oc0), .busy(busy[0]), .done(done[0]));

   move_gather_arbiter #(.N_CH(8), .DATA_W(32), .DEPTH(8), .MODE(1), .TAG_EN(1)) u_rr (
      .clk(clk), .reset(reset), .start(start[1]), .src_done(src_done[1]),
      .src_empty(src_empty[1]), .src_data(src_data[1]), .src_rden(src_rden[1]),
      .out_rden(out_rden[1]), .out_data(od1), .out_empty(out_empty[1]),
      .out_full(out_full[1]), .out_count(oc1), .busy(busy[1]), .done(done[1]));

   // Source FIFO model: registered empty, data valid the cycle after a read strobe.
   logic [31:0] smem [2][8][64];
   int          head [2][8];
   int          tail [2][8];
   logic [31:0] sdat [2][8];

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         src_empty[k] = '1;
         src_data[k]  = '0;
         for (int c = 0; c < 8; c++) begin
            src_empty[k][c]         = (head[k][c] == tail[k][c]);
            src_data[k][c*32 +: 32] = sdat[k][c];
         end
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 8; c++)
            if (src_rden[k][c]) begin
               sdat[k][c] <= smem[k][c][head[k][c][5:0]];
               head[k][c] <= head[k][c] + 1;
            end
   end

   // Output collector
   logic        acc [2];
   logic [34:0] rx  [2][256];
   int          rxn [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) acc[k] <= !reset && out_rden[k] && !out_empty[k];
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++)
         if (acc[k]) begin
            rx[k][rxn[k][7:0]] = od[k];
            rxn[k] = rxn[k] + 1;
         end
   end

   // Reference model: expected word stream per pass
   logic [34:0] expq [2][64];
   int          expn [2];
   int          base [2];
   int          rr_m [2];
   int          ncmp = 0;
   int          nfail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int k, input int c, input int n);
      for (int i = 0; i < n; i++) begin
         smem[k][c][tail[k][c][5:0]] = {c[3:0], tail[k][c][7:0], 20'($urandom)};
         tail[k][c]++;
      end
   endtask

   task automatic exp_from(input int k, input int c);
      for (int p = head[k][c]; p < tail[k][c]; p++) begin
         logic [31:0] w;
         w = smem[k][c][p[5:0]];
         expq[k][expn[k]] = (k == 1) ? {c[2:0], w} : {3'b000, w};
         expn[k]++;
      end
      rr_m[k] = c;
   endtask

   task automatic build_exp(input int k);
      int r0;
      int c;
      expn[k] = 0;
      r0 = rr_m[k];
      for (int j = 0; j < 8; j++) begin
         c = (k == 0) ? 7 - j : (r0 + 1 + j) % 8;
         if (src_done[k][c] && head[k][c] != tail[k][c]) exp_from(k, c);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input int k);
      base[k] = rxn[k];
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int pct, input string tag);
      int t = 0;
      while (!done[k] && t < 2000) begin
         out_rden[k] = ($urandom_range(99) < pct);
         @(negedge clk);
         t++;
      end
      out_rden[k] = 1'b0;
      chk({tag, " done"}, done[k], 1);
      chk({tag, " busy"}, busy[k], 0);
   endtask

   task automatic drain(input int k, input string tag);
      int t = 0;
      out_rden[k] = 1'b1;
      while (!out_empty[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      out_rden[k] = 1'b0;
      @(negedge clk);
      chk({tag, " drained"}, out_empty[k], 1);
   endtask

   task automatic compare(input int k, input string tag);
      chk({tag, " count"}, rxn[k] - base[k], expn[k]);
      for (int i = 0; i < expn[k]; i++) begin
         int p;
         p = base[k] + i;
         chk({tag, " word"}, rx[k][p[7:0]], expq[k][i]);
      end
   endtask

   task automatic run_pass(input int k, input int pct, input string tag);
      build_exp(k);
      pulse_start(k);
      wait_done(k, pct, tag);
      drain(k, tag);
      compare(k, tag);
   endtask

   task automatic chk_reset(input int k, input string tag);
      chk({tag, " rden"}, src_rden[k], 0);
      chk({tag, " data"}, od[k], 0);
      chk({tag, " empty"}, out_empty[k], 1);
      chk({tag, " full"}, out_full[k], 0);
      chk({tag, " count"}, oc[k], 0);
      chk({tag, " busy"}, busy[k], 0);
      chk({tag, " done"}, done[k], 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tags [6];
      int p;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; src_done[k] = '0; out_rden[k] = 1'b0; rr_m[k] = 7; base[k] = 0;
      end
      cyc(3);
      chk_reset(0, "rst0");
      chk_reset(1, "rst1");
      reset = 1'b0;
      cyc(2);

      // 1: fixed priority, ch7 x3 then ch2, with start/read latency
      src_done[0] = 8'hFF;
      push(0, 7, 3);
      push(0, 2, 1);
      build_exp(0);
      pulse_start(0);
      chk("t1 scan rden", src_rden[0], 8'h00);
      chk("t1 scan busy", busy[0], 1);
      @(negedge clk);
      chk("t1 first rden", src_rden[0], 8'h80);
      @(negedge clk);
      chk("t1 not yet visible", out_empty[0], 1);
      @(negedge clk);
      chk("t1 visible", out_empty[0], 0);
      wait_done(0, 50, "t1");
      drain(0, "t1");
      compare(0, "t1");
      p = base[0] + 3;
      chk("t1 last from ch2", rx[0][p[7:0]][31:28], 2);

      // 3: DEPTH 4 back-pressure with 6 words in ch0
      push(0, 0, 6);
      build_exp(0);
      pulse_start(0);
      cyc(20);
      chk("t3 count at depth", oc[0], 4);
      chk("t3 full", out_full[0], 1);
      chk("t3 rden stalled", src_rden[0], 8'h00);
      chk("t3 busy", busy[0], 1);
      chk("t3 not done", done[0], 0);
      out_rden[0] = 1'b1;
      cyc(2);
      out_rden[0] = 1'b0;
      cyc(10);
      chk("t3 done", done[0], 1);
      chk("t3 refilled", oc[0], 4);
      drain(0, "t3");
      compare(0, "t3");

      // 6b: read on empty changes nothing
      out_rden[0] = 1'b1;
      cyc(3);
      out_rden[0] = 1'b0;
      @(negedge clk);
      chk("t6 hold data", od[0], expq[0][expn[0]-1]);
      chk("t6 empty count", oc[0], 0);
      chk("t6 still empty", out_empty[0], 1);
      chk("t6 no extra words", rxn[0] - base[0], expn[0]);

      // 2: round-robin with tags, two passes
      src_done[1] = 8'hFF;
      push(1, 1, 2);
      push(1, 4, 2);
      push(1, 6, 2);
      run_pass(1, 60, "t2a");
      tags = '{1, 1, 4, 4, 6, 6};
      for (int i = 0; i < 6; i++) begin
         p = base[1] + i;
         chk("t2a tag", rx[1][p[7:0]][34:32], tags[i]);
      end
      push(1, 4, 2);
      push(1, 0, 1);
      push(1, 7, 2);
      run_pass(1, 60, "t2b");
      p = base[1];
      chk("t2b first tag", rx[1][p[7:0]][34:32], 7);
      p = base[1] + 3;
      chk("t2b wrap tag", rx[1][p[7:0]][34:32], 4);

      // 6a: streaming with simultaneous write and read keeps count at 1
      push(1, 3, 6);
      build_exp(1);
      out_rden[1] = 1'b1;
      pulse_start(1);
      @(negedge clk);
      chk("t6 b2b rden a", src_rden[1], 8'h08);
      @(negedge clk);
      chk("t6 b2b rden b", src_rden[1], 8'h08);
      @(negedge clk);
      chk("t6 count first", oc[1], 1);
      @(negedge clk);
      chk("t6 count rw a", oc[1], 1);
      @(negedge clk);
      chk("t6 count rw b", oc[1], 1);
      wait_done(1, 100, "t6");
      drain(1, "t6");
      compare(1, "t6");

      // 4: staggered src_done
      src_done[1] = 8'hD7;
      push(1, 3, 2);
      push(1, 5, 3);
      push(1, 1, 1);
      expn[1] = 0;
      exp_from(1, 1);
      exp_from(1, 3);
      exp_from(1, 5);
      pulse_start(1);
      for (int t = 1; t <= 42; t++) begin
         if (t == 10) src_done[1][3] = 1'b1;
         if (t == 40) src_done[1][5] = 1'b1;
         out_rden[1] = ($urandom_range(99) < 50);
         @(negedge clk);
         chk("t4 busy", busy[1], 1);
         chk("t4 not done", done[1], 0);
      end
      wait_done(1, 50, "t4");
      drain(1, "t4");
      compare(1, "t4");

      // 5: reset during DRAIN with a read pending
      push(0, 6, 5);
      build_exp(0);
      pulse_start(0);
      p = 0;
      while (src_rden[0] == 8'h00 && p < 10) begin
         @(negedge clk);
         p++;
      end
      chk("t5 read seen", src_rden[0], 8'h40);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset(0, "t5 rst");
      chk("t5 other done", done[1], 0);
      reset = 1'b0;
      rr_m[0] = 7;
      rr_m[1] = 7;
      @(negedge clk);
      chk("t5 idle after rst", src_rden[0], 8'h00);
      run_pass(0, 50, "t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
